cmd_fetch: RTL and testbench

CMD_FETCH -- requirements
Module: cmd_fetch

---
 rtl/cmd_pkg.sv | 18 +
 rtl/cmd_fetch.sv | 170 +++++++++++++++++
 tb/tb_cmd_fetch.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared command-path definitions: word width, end-of-program and padding words,
// and the fetch FSM encoding also used by the command buffer.
package cmd_pkg;

   localparam int DATA_W = 14;
   localparam logic [DATA_W-1:0] HALT_WORD = 14'h3FFF;
   localparam logic [DATA_W-1:0] NOP_WORD  = 14'h0000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_PUSH = 3'd3,
      ST_PAD  = 3'd4,
      ST_HALT = 3'd5
   } state_e;

endpackage

// File: rtl/cmd_fetch.sv
// Fetches command words from program memory one read at a time and pushes them
// into the command buffer in even/odd pairs, with branch redirect and halt.
module cmd_fetch #(
   parameter int                DATA_W    = cmd_pkg::DATA_W,
   parameter int                ADDR_W    = 8,
   parameter logic [DATA_W-1:0] HALT_WORD = cmd_pkg::HALT_WORD,
   parameter logic [DATA_W-1:0] NOP_WORD  = cmd_pkg::NOP_WORD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              buf_full,
   output logic              cmd_write,
   output logic [DATA_W-1:0] cmd_word,
   input  logic              branch_req,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              busy,
   output logic              halted
);

   cmd_pkg::state_e   state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;
   logic              phase_q, phase_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] word_q, word_d;

   logic              br_s;
   logic              pend_s;
   logic              wr_s;
   logic [ADDR_W-1:0] br_tgt_s;
   logic [ADDR_W-1:0] tgt_s;

   // Next-state, next-pc and pair/branch bookkeeping
   always_comb begin
      br_tgt_s = branch_addr & ~ADDR_W'(1);
      br_s     = branch_req && ((state_q == cmd_pkg::ST_REQ)  || (state_q == cmd_pkg::ST_WAIT) ||
                                (state_q == cmd_pkg::ST_PUSH) || (state_q == cmd_pkg::ST_PAD));
      tgt_s    = br_s ? br_tgt_s : tgt_q;
      pend_s   = pend_q | br_s;
      wr_s     = ((state_q == cmd_pkg::ST_PUSH) || (state_q == cmd_pkg::ST_PAD)) && !buf_full;

      state_d = state_q;
      pc_d    = pc_q;
      phase_d = phase_q;
      pend_d  = pend_s;
      tgt_d   = tgt_s;
      word_d  = word_q;

      case (state_q)
         cmd_pkg::ST_IDLE: begin
            if (start) state_d = cmd_pkg::ST_REQ;
            else       state_d = cmd_pkg::ST_IDLE;
         end
         cmd_pkg::ST_REQ: begin
            state_d = cmd_pkg::ST_WAIT;
         end
         cmd_pkg::ST_WAIT: begin
            // A response that arrives with a branch pending is stale and dropped
            if (mem_valid) begin
               if (pend_s) begin
                  if (!phase_q) begin
                     pc_d    = tgt_s;
                     phase_d = 1'b0;
                     pend_d  = 1'b0;
                     state_d = cmd_pkg::ST_REQ;
                  end else begin
                     state_d = cmd_pkg::ST_PAD;
                  end
               end else begin
                  word_d  = mem_data;
                  state_d = cmd_pkg::ST_PUSH;
               end
            end else begin
               state_d = cmd_pkg::ST_WAIT;
            end
         end
         cmd_pkg::ST_PUSH: begin
            if (wr_s) begin
               pc_d    = pc_q + ADDR_W'(1);
               phase_d = !phase_q;
               if (pend_s) begin
                  if (phase_q) begin
                     pc_d    = tgt_s;
                     phase_d = 1'b0;
                     pend_d  = 1'b0;
                     state_d = cmd_pkg::ST_REQ;
                  end else begin
                     state_d = cmd_pkg::ST_PAD;
                  end
               end else if (word_q == HALT_WORD) begin
                  state_d = phase_q ? cmd_pkg::ST_HALT : cmd_pkg::ST_PAD;
               end else begin
                  state_d = cmd_pkg::ST_REQ;
               end
            end else if (pend_s) begin
               // Unwritten word is abandoned; an open pair is closed with a NOP first
               if (phase_q) begin
                  state_d = cmd_pkg::ST_PAD;
               end else begin
                  pc_d    = tgt_s;
                  phase_d = 1'b0;
                  pend_d  = 1'b0;
                  state_d = cmd_pkg::ST_REQ;
               end
            end else begin
               state_d = cmd_pkg::ST_PUSH;
            end
         end
         cmd_pkg::ST_PAD: begin
            if (wr_s) begin
               phase_d = 1'b0;
               if (pend_s) begin
                  pc_d    = tgt_s;
                  pend_d  = 1'b0;
                  state_d = cmd_pkg::ST_REQ;
               end else begin
                  state_d = cmd_pkg::ST_HALT;
               end
            end else begin
               state_d = cmd_pkg::ST_PAD;
            end
         end
         cmd_pkg::ST_HALT: begin
            if (branch_req) begin
               pc_d    = br_tgt_s;
               phase_d = 1'b0;
               pend_d  = 1'b0;
               state_d = cmd_pkg::ST_REQ;
            end else begin
               state_d = cmd_pkg::ST_HALT;
            end
         end
         default: begin
            state_d = cmd_pkg::ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= cmd_pkg::ST_IDLE;
         pc_q    <= '0;
         tgt_q   <= '0;
         phase_q <= 1'b0;
         pend_q  <= 1'b0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
         word_q  <= word_d;
      end
   end

   assign mem_rd    = (state_q == cmd_pkg::ST_REQ);
   assign mem_addr  = pc_q;
   assign cmd_write = wr_s;
   assign cmd_word  = (state_q == cmd_pkg::ST_PAD) ? NOP_WORD : word_q;
   assign busy      = (state_q != cmd_pkg::ST_IDLE) && (state_q != cmd_pkg::ST_HALT);
   assign halted    = (state_q == cmd_pkg::ST_HALT);

endmodule

// File: tb/tb_cmd_fetch.sv
// Directed bench for cmd_fetch: program memory model with programmable latency,
// write/read loggers, and hand-computed expected sequences.
module tb_cmd_fetch;

   localparam int DW = 14;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic          mem_valid = 1'b0;
   logic [DW-1:0] mem_data = '0;
   logic          buf_full = 1'b0;
   logic          cmd_write;
   logic [DW-1:0] cmd_word;
   logic          branch_req = 1'b0;
   logic [AW-1:0] branch_addr = '0;
   logic          busy;
   logic          halted;

   logic [DW-1:0] mem [0:255];
   int            lat = 1;
   int            cnt = 0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] wr_q [$];
   logic [AW-1:0] rd_q [$];
   int            total = 0;
   int            bad = 0;
   int            blocked;

   always #5 clk = ~clk;

   cmd_fetch dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_valid  (mem_valid),
      .mem_data   (mem_data),
      .buf_full   (buf_full),
      .cmd_write  (cmd_write),
      .cmd_word   (cmd_word),
      .branch_req (branch_req),
      .branch_addr(branch_addr),
      .busy       (busy),
      .halted     (halted)
   );

   // Memory responder (latency counted in cycles after the read strobe) and loggers
   always @(negedge clk) begin
      mem_valid = 1'b0;
      if (cnt > 0) begin
         cnt = cnt - 1;
         if (cnt == 0) begin
            mem_valid = 1'b1;
            mem_data  = mem[rd_addr];
         end
      end
      if (mem_rd) begin
         cnt     = lat;
         rd_addr = mem_addr;
      end
      if (!reset && cmd_write) wr_q.push_back(cmd_word);
      if (!reset && mem_rd)    rd_q.push_back(mem_addr);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [31:0] exp);
      logic [31:0] got;
      got = (idx < wr_q.size()) ? 32'(wr_q[idx]) : 32'hFFFF_FFFF;
      check_val($sformatf("%s_wr%0d", tag, idx), got, exp);
   endtask

   task automatic check_rd(input string tag, input int idx, input logic [31:0] exp);
      logic [31:0] got;
      got = (idx < rd_q.size()) ? 32'(rd_q[idx]) : 32'hFFFF_FFFF;
      check_val($sformatf("%s_rd%0d", tag, idx), got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      branch_req = 1'b0;
      branch_addr = '0;
      buf_full = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      wr_q.delete();
      rd_q.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_halt(input string tag);
      int n = 0;
      while (!halted && n < 300) begin
         tick();
         n++;
      end
      check_val(tag, 32'(halted), 32'd1);
   endtask

   task automatic wait_writes(input int k);
      int n = 0;
      while (wr_q.size() < k && n < 50) begin
         tick();
         n++;
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({mem_rd, cmd_write, busy, halted, cmd_word, mem_addr});
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 14'h0100 | 14'(i);

      // Reset values
      repeat (2) tick();
      check_val("reset_outs", outs(), 32'd0);
      reset = 1'b0;
      tick();
      check_val("idle_outs", outs(), 32'd0);

      // Basic program with halt padding
      mem[0] = 14'h0011; mem[1] = 14'h0022; mem[2] = 14'h3FFF; mem[3] = 14'h1234;
      lat = 1;
      do_reset();
      pulse_start();
      wait_halt("t1_halt");
      check_val("t1_nwr", wr_q.size(), 32'd4);
      check_wr("t1", 0, 32'h0011);
      check_wr("t1", 1, 32'h0022);
      check_wr("t1", 2, 32'h3FFF);
      check_wr("t1", 3, 32'h0000);
      check_val("t1_busy", 32'(busy), 32'd0);
      check_val("t1_pc", 32'(mem_addr), 32'd3);
      check_val("t1_nrd", rd_q.size(), 32'd3);
      pulse_start();
      repeat (4) tick();
      check_val("t1_start_in_halt", 32'(halted), 32'd1);
      check_val("t1_no_new_rd", rd_q.size(), 32'd3);

      // Buffer back-pressure for five PUSH cycles on the second word
      do_reset();
      pulse_start();
      wait_writes(1);
      buf_full = 1'b1;
      blocked = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (cmd_word == 14'h0022 && !cmd_write) blocked++;
         tick();
      end
      check_val("t2_blocked", blocked, 32'd5);
      check_val("t2_nwr_held", wr_q.size(), 32'd1);
      check_val("t2_pc_held", 32'(mem_addr), 32'd1);
      buf_full = 1'b0;
      @(negedge clk);
      check_val("t2_wr_now", 32'(cmd_write), 32'd1);
      check_val("t2_wr_word", 32'(cmd_word), 32'h0022);
      tick();
      check_val("t2_pc_adv", 32'(mem_addr), 32'd2);
      wait_halt("t2_halt");
      check_val("t2_nwr", wr_q.size(), 32'd4);
      check_wr("t2", 1, 32'h0022);
      check_wr("t2", 3, 32'h0000);

      // Branch while waiting on a slow read: stale data dropped
      mem[16'h14] = 14'h00AA; mem[16'h15] = 14'h3FFF;
      lat = 3;
      do_reset();
      pulse_start();
      tick();
      branch_req = 1'b1;
      branch_addr = 8'h15;
      tick();
      branch_req = 1'b0;
      wait_halt("t3_halt");
      check_val("t3_nwr", wr_q.size(), 32'd2);
      check_wr("t3", 0, 32'h00AA);
      check_wr("t3", 1, 32'h3FFF);
      check_rd("t3", 0, 32'h00);
      check_rd("t3", 1, 32'h14);

      // Branch with an open pair: NOP closes it before the redirect
      mem[16'h30] = 14'h0055; mem[16'h31] = 14'h3FFF;
      lat = 1;
      do_reset();
      pulse_start();
      wait_writes(1);
      branch_req = 1'b1;
      branch_addr = 8'h31;
      tick();
      branch_req = 1'b0;
      wait_halt("t4_halt");
      check_val("t4_nwr", wr_q.size(), 32'd4);
      check_wr("t4", 0, 32'h0011);
      check_wr("t4", 1, 32'h0000);
      check_wr("t4", 2, 32'h0055);
      check_wr("t4", 3, 32'h3FFF);
      check_rd("t4", 2, 32'h30);
      check_rd("t4", 3, 32'h31);

      // Branch coinciding with a write: write counts, then pad, then redirect
      mem[16'h40] = 14'h3FFF;
      do_reset();
      pulse_start();
      tick();
      tick();
      branch_req = 1'b1;
      branch_addr = 8'h41;
      tick();
      branch_req = 1'b0;
      wait_halt("t5_halt");
      check_val("t5_nwr", wr_q.size(), 32'd4);
      check_wr("t5", 0, 32'h0011);
      check_wr("t5", 1, 32'h0000);
      check_wr("t5", 2, 32'h3FFF);
      check_val("t5_nrd", rd_q.size(), 32'd2);
      check_rd("t5", 1, 32'h40);

      // Branch out of HALT and pc wrap from 0xFF to 0x00
      mem[16'hFE] = 14'h0071; mem[16'hFF] = 14'h0072; mem[0] = 14'h3FFF; mem[1] = 14'h3FFF;
      wr_q.delete();
      rd_q.delete();
      branch_req = 1'b1;
      branch_addr = 8'hFF;
      tick();
      branch_req = 1'b0;
      check_val("t6_unhalt", 32'(halted), 32'd0);
      check_val("t6_busy", 32'(busy), 32'd1);
      wait_halt("t6_halt");
      check_rd("t6", 0, 32'hFE);
      check_rd("t6", 1, 32'hFF);
      check_rd("t6", 2, 32'h00);
      check_wr("t6", 1, 32'h0072);
      check_wr("t6", 3, 32'h0000);

      // Reset during WAIT with a late response, then branch in IDLE
      mem[0] = 14'h0011;
      lat = 4;
      do_reset();
      pulse_start();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (8) tick();
      check_val("t7_no_wr", wr_q.size(), 32'd0);
      check_val("t7_outs", outs(), 32'd0);
      branch_req = 1'b1;
      branch_addr = 8'h20;
      tick();
      branch_req = 1'b0;
      repeat (3) tick();
      check_val("t7_idle_branch", outs(), 32'd0);
      check_val("t7_nrd", rd_q.size(), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
